// File: rtl/tube_collision_score.sv
// tube_collision_score: bird/tube/ground collision, BCD scoring and game FSM.
// Optional macro HIGH_SCORE_EN keeps the best score across game restarts.
module tube_collision_score #(
    parameter int SCREEN_HEIGHT = 768,
    parameter int TUBE_WIDTH    = 120,
    parameter int GAP_HEIGHT    = 250,
    parameter int BIRD_X        = 200,
    parameter int BIRD_SIZE     = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             game_rst,
    input  logic             start,
    input  logic             frame_tick,
    input  logic [2:0][10:0] tube_x,
    input  logic [2:0][10:0] gap_y,
    input  logic [10:0]      bird_y,
    output logic [1:0]       game_state,
    output logic             collision,
    output logic             pass_pulse,
    output logic [15:0]      score_bcd,
    output logic [15:0]      hi_score_bcd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2
    } state_e;

    localparam logic signed [12:0] SH = 13'(SCREEN_HEIGHT);
    localparam logic signed [12:0] TW = 13'(TUBE_WIDTH);
    localparam logic signed [12:0] GH = 13'(GAP_HEIGHT);
    localparam logic signed [12:0] BX = 13'(BIRD_X);
    localparam logic signed [12:0] BS = 13'(BIRD_SIZE);

    // Zero-extend a pixel coordinate into the signed compare domain
    function automatic logic signed [12:0] ext(input logic [10:0] v);
        return signed'({2'b00, v});
    endfunction

    state_e             state_q, state_d;
    logic               s1_vld_q, s1_vld_d;
    logic [2:0][10:0]   s1_tx_q, s1_tx_d;
    logic [2:0][10:0]   s1_gy_q, s1_gy_d;
    logic [10:0]        s1_by_q, s1_by_d;
    logic               s2_vld_q, s2_vld_d;
    logic               s2_hit_q, s2_hit_d;
    logic [1:0]         s2_cnt_q, s2_cnt_d;
    logic [2:0]         flag_q, flag_d;
    logic [2:0]         pass_new;
    logic [15:0]        score_q, score_d;
    logic [15:0]        bcd_sum;
    logic [4:0]         dsum;
    logic [1:0]         carry;
    logic signed [12:0] by_top, by_bot;
    logic               tube_hit, ground_hit;
    logic               flag_en, eval;

    // Stage 1: capture the frame's positions on the strobe
    always_comb begin
        s1_vld_d = frame_tick && !game_rst;
        s1_tx_d  = s1_tx_q;
        s1_gy_d  = s1_gy_q;
        s1_by_d  = s1_by_q;
        if (s1_vld_d) begin
            s1_tx_d = tube_x;
            s1_gy_d = gap_y;
            s1_by_d = bird_y;
        end
    end

    // Stage 2: overlap tests, ground test and per-tube pass tracking
    always_comb begin
        by_top     = ext(s1_by_q);
        by_bot     = by_top + BS;
        ground_hit = by_bot >= SH;
        tube_hit   = 1'b0;
        pass_new   = '0;
        flag_d     = flag_q;
        flag_en    = s1_vld_q && (state_q == PLAY) && !collision;
        for (int i = 0; i < 3; i++) begin
            if ((ext(s1_tx_q[i]) - TW < BX + BS)
                && (ext(s1_tx_q[i]) > BX)
                && ((by_top < ext(s1_gy_q[i]))
                    || (by_bot > ext(s1_gy_q[i]) + GH)))
                tube_hit = 1'b1;
            if (flag_en) begin
                if (ext(s1_tx_q[i]) <= BX && !flag_q[i]) begin
                    flag_d[i]   = 1'b1;
                    pass_new[i] = 1'b1;
                end else if (ext(s1_tx_q[i]) > BX + BS) begin
                    flag_d[i] = 1'b0;
                end
            end
        end
        if (game_rst)
            flag_d = '0;
        s2_vld_d = s1_vld_q && !game_rst;
        s2_hit_d = tube_hit || ground_hit;
        s2_cnt_d = 2'(pass_new[0]) + 2'(pass_new[1])
                 + 2'(pass_new[2]);
    end

    // BCD add of the pass count with ripple carry, saturating at 9999
    always_comb begin
        bcd_sum = '0;
        carry   = s2_cnt_q;
        dsum    = '0;
        for (int i = 0; i < 4; i++) begin
            dsum = {1'b0, score_q[4*i +: 4]} + {3'b000, carry};
            if (dsum >= 5'd10) begin
                bcd_sum[4*i +: 4] = 4'(dsum - 5'd10);
                carry = 2'd1;
            end else begin
                bcd_sum[4*i +: 4] = dsum[3:0];
                carry = 2'd0;
            end
        end
        if (carry != 2'd0)
            bcd_sum = 16'h9999;
    end

    // Stage 3: game FSM, score update and event pulses; a hit beats passes
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        collision  = 1'b0;
        pass_pulse = 1'b0;
        eval       = s2_vld_q && !game_rst;
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = PLAY;
            end
            PLAY: begin
                if (eval && s2_hit_q) begin
                    state_d   = HIT;
                    collision = 1'b1;
                end else if (eval && s2_cnt_q != 2'd0) begin
                    score_d    = bcd_sum;
                    pass_pulse = 1'b1;
                end
            end
            HIT: begin
                state_d = HIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (game_rst) begin
            state_d = IDLE;
            score_d = '0;
        end
    end

    // Pipeline, pass flags and game state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s1_vld_q <= 1'b0;
            s1_tx_q  <= '0;
            s1_gy_q  <= '0;
            s1_by_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_hit_q <= 1'b0;
            s2_cnt_q <= '0;
            flag_q   <= '0;
            score_q  <= '0;
        end else begin
            state_q  <= state_d;
            s1_vld_q <= s1_vld_d;
            s1_tx_q  <= s1_tx_d;
            s1_gy_q  <= s1_gy_d;
            s1_by_q  <= s1_by_d;
            s2_vld_q <= s2_vld_d;
            s2_hit_q <= s2_hit_d;
            s2_cnt_q <= s2_cnt_d;
            flag_q   <= flag_d;
            score_q  <= score_d;
        end
    end

    assign game_state = state_q;
    assign score_bcd  = score_q;

`ifdef HIGH_SCORE_EN
    logic [15:0] hi_q, hi_d;

    // Keep the larger of the best and the final score when a game ends
    always_comb begin
        hi_d = hi_q;
        if (collision && score_q > hi_q)
            hi_d = score_q;
    end

    // Best score survives game restarts; only the hard reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hi_q <= '0;
        else
            hi_q <= hi_d;
    end

    assign hi_score_bcd = hi_q;
`else
    assign hi_score_bcd = 16'h0000;
`endif

endmodule

// File: tb/tb_tube_collision_score.sv
// tb_tube_collision_score: scoreboard bench for tube_collision_score.
// Expectations come from a behavioural game model run at each frame strobe.
module tb_tube_collision_score;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             game_rst = 1'b0;
    logic             start = 1'b0;
    logic             frame_tick = 1'b0;
    logic [2:0][10:0] tube_x = '0;
    logic [2:0][10:0] gap_y = '0;
    logic [10:0]      bird_y = '0;
    logic [1:0]       game_state;
    logic             collision;
    logic             pass_pulse;
    logic [15:0]      score_bcd;
    logic [15:0]      hi_score_bcd;

`ifdef HIGH_SCORE_EN
    localparam logic [15:0] HI_WANT = 16'h0012;
`else
    localparam logic [15:0] HI_WANT = 16'h0000;
`endif

    typedef struct {
        logic        coll;
        logic        pp;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] hi;
    } exp_t;

    exp_t     exp_q[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    int       m_state = 0;
    int       m_score = 0;
    int       m_hi = 0;
    bit [2:0] m_flag = '0;

    tube_collision_score dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .game_rst     (game_rst),
        .start        (start),
        .frame_tick   (frame_tick),
        .tube_x       (tube_x),
        .gap_y        (gap_y),
        .bird_y       (bird_y),
        .game_state   (game_state),
        .collision    (collision),
        .pass_pulse   (pass_pulse),
        .score_bcd    (score_bcd),
        .hi_score_bcd (hi_score_bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        edge1();
        start = 1'b0;
        if (m_state == 0)
            m_state = 1;
    endtask

    task automatic do_grst();
        game_rst = 1'b1;
        edge1();
        game_rst = 1'b0;
        m_state = 0;
        m_score = 0;
        m_flag  = '0;
    endtask

    // Drive one frame strobe and push what the game model predicts
    task automatic send(input int t0, input int t1, input int t2,
                        input int g0, input int g1, input int g2,
                        input int by);
        int   tv[3];
        int   gv[3];
        int   np;
        bit   hit;
        exp_t e;
        tv[0] = t0; tv[1] = t1; tv[2] = t2;
        gv[0] = g0; gv[1] = g1; gv[2] = g2;
        tube_x[0] = 11'(t0);
        tube_x[1] = 11'(t1);
        tube_x[2] = 11'(t2);
        gap_y[0]  = 11'(g0);
        gap_y[1]  = 11'(g1);
        gap_y[2]  = 11'(g2);
        bird_y    = 11'(by);
        frame_tick = 1'b1;
        hit = (by + 40 >= 768);
        np = 0;
        e.coll = 1'b0;
        e.pp   = 1'b0;
        if (m_state == 1) begin
            for (int i = 0; i < 3; i++) begin
                if (tv[i] - 120 < 240 && tv[i] > 200
                    && (by < gv[i] || by + 40 > gv[i] + 250))
                    hit = 1'b1;
                if (tv[i] <= 200 && !m_flag[i]) begin
                    m_flag[i] = 1'b1;
                    np++;
                end else if (tv[i] > 240) begin
                    m_flag[i] = 1'b0;
                end
            end
            if (hit) begin
                e.coll = 1'b1;
                m_state = 2;
`ifdef HIGH_SCORE_EN
                if (m_score > m_hi)
                    m_hi = m_score;
`endif
            end else if (np > 0) begin
                e.pp = 1'b1;
                m_score = (m_score + np > 9999) ? 9999 : m_score + np;
            end
        end
        e.st = 2'(m_state);
        e.sc = to_bcd(m_score);
        e.hi = to_bcd(m_hi);
        exp_q.push_back(e);
        edge1();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({game_state, score_bcd, hi_score_bcd, collision, pass_pulse}
            !== 36'd0) begin
            n_bad++;
            $display("FAIL reset: got st=%0d sc=%h hi=%h c=%b p=%b, want all 0",
                     game_state, score_bcd, hi_score_bcd, collision, pass_pulse);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edge1();
    endtask

    task automatic test_start_clear();
        exp_t e;
        do_start();
        n_cmp++;
        if (game_state !== 2'd1) begin
            n_bad++;
            $display("FAIL start: got st=%0d, want 1", game_state);
        end
        send(1100, 1450, 1800, 250, 250, 250, 300);
        skip(2);
        e = exp_q.pop_front();
        n_cmp++;
        if (collision !== e.coll || pass_pulse !== e.pp) begin
            n_bad++;
            $display("FAIL clear_pulse: got c=%b p=%b, want c=%b p=%b",
                     collision, pass_pulse, e.coll, e.pp);
        end
        skip(1);
        n_cmp++;
        if (game_state !== e.st || score_bcd !== e.sc
            || hi_score_bcd !== e.hi || collision || pass_pulse) begin
            n_bad++;
            $display("FAIL clear_state: got st=%0d sc=%h hi=%h, want st=%0d sc=%h hi=%h",
                     game_state, score_bcd, hi_score_bcd, e.st, e.sc, e.hi);
        end
    endtask

    task automatic test_tube_hit();
        int   rows[3][5] = '{'{300, 1450, 1800, 100, 400},
                             '{300, 1450, 1800, 100, 400},
                             '{190, 1450, 1800, 250, 300}};
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            edge1();
            send(rows[k][0], rows[k][1], rows[k][2],
                 rows[k][3], 250, 250, rows[k][4]);
            skip(2);
            e = exp_q.pop_front();
            n_cmp++;
            if (collision !== e.coll || pass_pulse !== e.pp) begin
                n_bad++;
                $display("FAIL tube_hit_pulse k=%0d: got c=%b p=%b, want c=%b p=%b",
                         k, collision, pass_pulse, e.coll, e.pp);
            end
            skip(1);
            n_cmp++;
            if (game_state !== e.st || score_bcd !== e.sc
                || hi_score_bcd !== e.hi || collision || pass_pulse) begin
                n_bad++;
                $display("FAIL tube_hit_state k=%0d: got st=%0d sc=%h, want st=%0d sc=%h",
                         k, game_state, score_bcd, e.st, e.sc);
            end
        end
    endtask

    task automatic test_ground_hit();
        exp_t e;
        edge1();
        do_grst();
        do_start();
        send(1100, 1450, 1800, 250, 250, 250, 730);
        skip(2);
        e = exp_q.pop_front();
        n_cmp++;
        if (collision !== e.coll || pass_pulse !== e.pp) begin
            n_bad++;
            $display("FAIL ground_pulse: got c=%b p=%b, want c=%b p=%b",
                     collision, pass_pulse, e.coll, e.pp);
        end
        skip(1);
        n_cmp++;
        if (game_state !== e.st || score_bcd !== e.sc || collision) begin
            n_bad++;
            $display("FAIL ground_state: got st=%0d sc=%h, want st=%0d sc=%h",
                     game_state, score_bcd, e.st, e.sc);
        end
        edge1();
        game_rst = 1'b1;
        start    = 1'b1;
        edge1();
        game_rst = 1'b0;
        start    = 1'b0;
        m_state = 0;
        m_score = 0;
        m_flag  = '0;
        n_cmp++;
        if (game_state !== 2'd0 || score_bcd !== 16'h0000) begin
            n_bad++;
            $display("FAIL rst_beats_start: got st=%0d sc=%h, want st=0 sc=0000",
                     game_state, score_bcd);
        end
    endtask

    task automatic test_scoring();
        int   rows[12][3] = '{'{190, 1450, 1800}, '{190, 1450, 1800},
                              '{1144, 1450, 1800}, '{190, 1450, 1800},
                              '{1144, 1144, 1144}, '{190, 190, 190},
                              '{1144, 1144, 1144}, '{190, 190, 190},
                              '{1144, 1144, 1144}, '{190, 1144, 1144},
                              '{1144, 1144, 1144}, '{190, 190, 1144}};
        exp_t e;
        edge1();
        do_start();
        for (int k = 0; k < 12; k++) begin
            send(rows[k][0], rows[k][1], rows[k][2], 250, 250, 250, 300);
            skip(2);
            e = exp_q.pop_front();
            n_cmp++;
            if (collision !== e.coll || pass_pulse !== e.pp) begin
                n_bad++;
                $display("FAIL score_pulse k=%0d: got c=%b p=%b, want c=%b p=%b",
                         k, collision, pass_pulse, e.coll, e.pp);
            end
            skip(1);
            n_cmp++;
            if (game_state !== e.st || score_bcd !== e.sc
                || collision || pass_pulse) begin
                n_bad++;
                $display("FAIL score_state k=%0d: got st=%0d sc=%h, want st=%0d sc=%h",
                         k, game_state, score_bcd, e.st, e.sc);
            end
            edge1();
        end
        n_cmp++;
        if (score_bcd !== 16'h0011) begin
            n_bad++;
            $display("FAIL score_carry: got %h, want 0011", score_bcd);
        end
    endtask

    task automatic test_back_to_back();
        exp_t ea, eb;
        send(1144, 1144, 190, 250, 250, 250, 300);
        send(190, 190, 190, 250, 250, 250, 300);
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        skip(1);
        n_cmp++;
        if (collision !== ea.coll || pass_pulse !== ea.pp) begin
            n_bad++;
            $display("FAIL b2b_pulse_a: got c=%b p=%b, want c=%b p=%b",
                     collision, pass_pulse, ea.coll, ea.pp);
        end
        skip(1);
        n_cmp++;
        if (collision !== eb.coll || pass_pulse !== eb.pp
            || score_bcd !== ea.sc) begin
            n_bad++;
            $display("FAIL b2b_mid: got c=%b p=%b sc=%h, want c=%b p=%b sc=%h",
                     collision, pass_pulse, score_bcd, eb.coll, eb.pp, ea.sc);
        end
        skip(1);
        n_cmp++;
        if (score_bcd !== eb.sc || game_state !== eb.st
            || score_bcd !== 16'h0014 || pass_pulse) begin
            n_bad++;
            $display("FAIL b2b_end: got st=%0d sc=%h, want st=%0d sc=%h",
                     game_state, score_bcd, eb.st, eb.sc);
        end
    endtask

    task automatic test_hi_score();
        int   rows[12][6] = '{'{1144, 1144, 1144, 250, 300, 1},
                              '{190, 190, 190, 250, 300, 0},
                              '{1144, 1144, 1144, 250, 300, 0},
                              '{190, 190, 190, 250, 300, 0},
                              '{1144, 1144, 1144, 250, 300, 0},
                              '{190, 190, 190, 250, 300, 0},
                              '{1144, 1144, 1144, 250, 300, 0},
                              '{190, 190, 190, 250, 300, 0},
                              '{300, 1450, 1800, 100, 400, 0},
                              '{1144, 1144, 1144, 250, 300, 1},
                              '{190, 190, 190, 250, 300, 0},
                              '{300, 1450, 1800, 100, 400, 0}};
        exp_t e;
        for (int k = 0; k < 12; k++) begin
            edge1();
            if (rows[k][5] != 0) begin
                do_grst();
                do_start();
            end
            send(rows[k][0], rows[k][1], rows[k][2],
                 rows[k][3], 250, 250, rows[k][4]);
            skip(2);
            e = exp_q.pop_front();
            n_cmp++;
            if (collision !== e.coll || pass_pulse !== e.pp) begin
                n_bad++;
                $display("FAIL hi_pulse k=%0d: got c=%b p=%b, want c=%b p=%b",
                         k, collision, pass_pulse, e.coll, e.pp);
            end
            skip(1);
            n_cmp++;
            if (game_state !== e.st || score_bcd !== e.sc
                || hi_score_bcd !== e.hi) begin
                n_bad++;
                $display("FAIL hi_state k=%0d: got st=%0d sc=%h hi=%h, want st=%0d sc=%h hi=%h",
                         k, game_state, score_bcd, hi_score_bcd, e.st, e.sc, e.hi);
            end
        end
        n_cmp++;
        if (hi_score_bcd !== HI_WANT) begin
            n_bad++;
            $display("FAIL hi_final: got %h, want %h", hi_score_bcd, HI_WANT);
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        int   t2;
        edge1();
        do_grst();
        do_start();
        for (int f = 0; f < 6668; f++) begin
            t2 = (f < 6664) ? 190 : 1144;
            if (f % 2 == 0)
                send(1144, 1144, 1144, 250, 250, 250, 300);
            else
                send(190, 190, t2, 250, 250, 250, 300);
            skip(2);
            e = exp_q.pop_front();
            n_cmp++;
            if (collision !== e.coll || pass_pulse !== e.pp) begin
                n_bad++;
                $display("FAIL sat_pulse f=%0d: got c=%b p=%b, want c=%b p=%b",
                         f, collision, pass_pulse, e.coll, e.pp);
            end
            skip(1);
            n_cmp++;
            if (score_bcd !== e.sc || game_state !== e.st) begin
                n_bad++;
                $display("FAIL sat_state f=%0d: got st=%0d sc=%h, want st=%0d sc=%h",
                         f, game_state, score_bcd, e.st, e.sc);
            end
            edge1();
        end
        n_cmp++;
        if (score_bcd !== 16'h9999) begin
            n_bad++;
            $display("FAIL saturate: got %h, want 9999", score_bcd);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_grst();
        do_start();
        for (int k = 0; k < 9; k++) begin
            if (k % 2 == 0)
                send(190, 1144, 1144, 250, 250, 250, 300);
            else
                send(1144, 1144, 1144, 250, 250, 250, 300);
            skip(2);
            e = exp_q.pop_front();
            skip(1);
            n_cmp++;
            if (score_bcd !== e.sc || game_state !== e.st) begin
                n_bad++;
                $display("FAIL ar_state k=%0d: got st=%0d sc=%h, want st=%0d sc=%h",
                         k, game_state, score_bcd, e.st, e.sc);
            end
            if (k < 8)
                edge1();
        end
        #1 rst_n = 1'b0;
        #1;
        m_state = 0;
        m_score = 0;
        m_hi    = 0;
        m_flag  = '0;
        n_cmp++;
        if ({game_state, score_bcd, hi_score_bcd, collision, pass_pulse}
            !== 36'd0) begin
            n_bad++;
            $display("FAIL async_reset: got st=%0d sc=%h hi=%h c=%b p=%b, want all 0",
                     game_state, score_bcd, hi_score_bcd, collision, pass_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        edge1();
    endtask

    initial begin
        test_reset();
        test_start_clear();
        test_tube_hit();
        test_ground_hit();
        test_scoring();
        test_back_to_back();
        test_hi_score();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
